// File: rtl/ivl_uvm_ovl_fire_monitor.sv
// Monitor for OVL checker fire pulses. It keeps sticky and saturating per-checker counts,
// captures the first failure with a timestamp, and queues each fire event for a consumer.
module ivl_uvm_ovl_fire_monitor #(
    parameter int unsigned NUM_CHK    = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_CHK-1:0] fire_in,
    input  logic [3:0]         cnt_sel,
    output logic [CNT_W-1:0]   fire_cnt,
    output logic [NUM_CHK-1:0] sticky,
    output logic               any_fire,
    output logic               first_valid,
    output logic [NUM_CHK-1:0] first_mask,
    output logic [TS_W-1:0]    first_ts,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [NUM_CHK-1:0] ev_mask,
    output logic [TS_W-1:0]    ev_ts,
    output logic               overflow,
    output logic [7:0]         drop_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [NUM_CHK-1:0] mask;
        logic [TS_W-1:0]    ts;
    } ev_t;

    logic [TS_W-1:0]    ts_q, ts_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CHK];
    logic [CNT_W-1:0]   cnt_d [NUM_CHK];
    logic [NUM_CHK-1:0] sticky_q, sticky_d;
    logic               first_valid_q, first_valid_d;
    logic [NUM_CHK-1:0] first_mask_q, first_mask_d;
    logic [TS_W-1:0]    first_ts_q, first_ts_d;
    ev_t                mem_q [FIFO_DEPTH];
    ev_t                mem_d [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic ev, empty, full, pop, push, drop;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    always_comb begin
        ev    = enable && !clear && (fire_in != '0);
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop   = !empty && ev_ready && !clear;
        push  = ev && (!full || pop);
        drop  = ev && full && !pop;
    end

    always_comb begin
        ts_d          = ts_q + TS_W'(1);
        cnt_d         = cnt_q;
        sticky_d      = sticky_q;
        first_valid_d = first_valid_q;
        first_mask_d  = first_mask_q;
        first_ts_d    = first_ts_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        overflow_d    = overflow_q;
        drop_cnt_d    = drop_cnt_q;

        if (clear) begin
            for (int unsigned i = 0; i < NUM_CHK; i++) begin
                cnt_d[i] = '0;
            end
            sticky_d      = '0;
            first_valid_d = 1'b0;
            first_mask_d  = '0;
            first_ts_d    = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            overflow_d    = 1'b0;
            drop_cnt_d    = '0;
        end else begin
            if (ev) begin
                sticky_d = sticky_q | fire_in;
                for (int unsigned i = 0; i < NUM_CHK; i++) begin
                    if (fire_in[i] && (cnt_q[i] != '1)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                if (!first_valid_q) begin
                    first_valid_d = 1'b1;
                    first_mask_d  = fire_in;
                    first_ts_d    = ts_q;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = '{mask: fire_in, ts: ts_q};
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q          <= '0;
            for (int unsigned i = 0; i < NUM_CHK; i++) begin
                cnt_q[i] <= '0;
            end
            sticky_q      <= '0;
            first_valid_q <= 1'b0;
            first_mask_q  <= '0;
            first_ts_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            ts_q          <= ts_d;
            cnt_q         <= cnt_d;
            sticky_q      <= sticky_d;
            first_valid_q <= first_valid_d;
            first_mask_q  <= first_mask_d;
            first_ts_q    <= first_ts_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Storage needs no reset: head fields are masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        fire_cnt = '0;
        for (int unsigned i = 0; i < NUM_CHK; i++) begin
            if (cnt_sel == 4'(i)) begin
                fire_cnt = cnt_q[i];
            end
        end
    end

    assign sticky      = sticky_q;
    assign any_fire    = |sticky_q;
    assign first_valid = first_valid_q;
    assign first_mask  = first_mask_q;
    assign first_ts    = first_ts_q;
    assign ev_valid    = !empty;
    assign ev_mask     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]].mask;
    assign ev_ts       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]].ts;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_monitor.sv
// Scoreboard bench for ivl_uvm_ovl_fire_monitor: expected events are queued when driven
// and compared against the FIFO head as the bench pops it.
module tb_ivl_uvm_ovl_fire_monitor;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [3:0]  fire_in;
    logic [3:0]  cnt_sel;
    logic [7:0]  fire_cnt;
    logic [3:0]  sticky;
    logic        any_fire;
    logic        first_valid;
    logic [3:0]  first_mask;
    logic [15:0] first_ts;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_mask;
    logic [15:0] ev_ts;
    logic        overflow;
    logic [7:0]  drop_cnt;

    ivl_uvm_ovl_fire_monitor #(
        .NUM_CHK(4), .CNT_W(8), .TS_W(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .fire_in(fire_in), .cnt_sel(cnt_sel), .fire_cnt(fire_cnt),
        .sticky(sticky), .any_fire(any_fire), .first_valid(first_valid),
        .first_mask(first_mask), .first_ts(first_ts), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_mask(ev_mask), .ev_ts(ev_ts),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  mask;
        logic [15:0] ts;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_cnt [4];
    logic [3:0]  m_sticky;
    logic        m_fv;
    logic [3:0]  m_fmask;
    logic [15:0] m_fts;
    logic        m_ovf;
    logic [7:0]  m_drop;
    logic [15:0] mts;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_cnt[i] = 8'd0;
        m_sticky = 4'd0;
        m_fv     = 1'b0;
        m_fmask  = 4'd0;
        m_fts    = 16'd0;
        m_ovf    = 1'b0;
        m_drop   = 8'd0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, advance the reference model, sample 1 time unit after the edge.
    task automatic step(input logic [3:0] f, input logic en, input logic clr, input logic rdy);
        logic ev, pop;
        fire_in  = f;
        enable   = en;
        clear    = clr;
        ev_ready = rdy;
        ev  = en && !clr && (f != 4'd0);
        pop = rdy && !clr && (exp_q.size() > 0);
        if (clr) begin
            model_clear();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (ev) begin
                m_sticky = m_sticky | f;
                for (int i = 0; i < 4; i++)
                    if (f[i] && m_cnt[i] != 8'hFF) m_cnt[i] = m_cnt[i] + 8'd1;
                if (!m_fv) begin
                    m_fv = 1'b1; m_fmask = f; m_fts = mts;
                end
                if (exp_q.size() < DEPTH) exp_q.push_back(exp_t'{f, mts});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end
            end
        end
        @(posedge clock);
        #1;
        mts = mts + 16'd1;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; clear = 1'b0; fire_in = 4'd0;
        ev_ready = 1'b0; cnt_sel = 4'd0;
        model_clear();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        mts = 16'd0;
    endtask

    task automatic test_drain(input string tag);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 16) begin
            exp_t h = exp_q[0];
            n_vec++;
            if (ev_valid !== 1'b1 || ev_mask !== h.mask || ev_ts !== h.ts) begin
                n_err++;
                $display("FAIL %s_pop%0d: got valid=%b mask=%b ts=%0d, want valid=1 mask=%b ts=%0d",
                         tag, guard, ev_valid, ev_mask, ev_ts, h.mask, h.ts);
            end
            step(4'd0, 1'b1, 1'b0, 1'b1);
            guard++;
        end
        n_vec++;
        if (ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_empty: ev_valid=%b want 0", tag, ev_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({sticky, any_fire, first_valid, first_mask, first_ts, ev_valid, ev_mask, ev_ts,
             overflow, drop_cnt, fire_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: sticky=%b any=%b fv=%b fm=%b fts=%0d evv=%b ovf=%b drop=%0d cnt=%0d, want all 0",
                     sticky, any_fire, first_valid, first_mask, first_ts, ev_valid, overflow, drop_cnt, fire_cnt);
        end
        for (int i = 0; i < 10; i++) step(4'd0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (sticky !== 4'd0 || first_valid !== 1'b0 || ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: sticky=%b fv=%b evv=%b, want 0", sticky, first_valid, ev_valid);
        end
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (first_ts !== 16'd10 || first_mask !== 4'b0100) begin
            n_err++;
            $display("FAIL ts_after_10: first_ts=%0d mask=%b, want 10 0100", first_ts, first_mask);
        end
        test_drain("ts10");
    endtask

    task automatic test_first_fail();
        do_reset();
        for (int i = 0; i < 5; i++) step(4'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 1'b0, 1'b0);
        cnt_sel = 4'd1; #1;
        n_vec++;
        if (sticky !== 4'b0010 || any_fire !== 1'b1 || fire_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL first_counts: sticky=%b any=%b cnt=%0d, want 0010 1 3", sticky, any_fire, fire_cnt);
        end
        n_vec++;
        if (first_valid !== 1'b1 || first_mask !== 4'b0010 || first_ts !== 16'd5) begin
            n_err++;
            $display("FAIL first_capture: fv=%b mask=%b ts=%0d, want 1 0010 5", first_valid, first_mask, first_ts);
        end
        cnt_sel = 4'd9; #1;
        n_vec++;
        if (fire_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL cnt_sel_range: cnt=%0d want 0", fire_cnt);
        end
        cnt_sel = 4'd0;
        test_drain("first");
    endtask

    task automatic test_overflow();
        step(4'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(4'b0001, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd2 || drop_cnt !== m_drop) begin
            n_err++;
            $display("FAIL overflow: ovf=%b drop=%0d, want 1 2", overflow, drop_cnt);
        end
        cnt_sel = 4'd0; #1;
        n_vec++;
        if (fire_cnt !== m_cnt[0]) begin
            n_err++;
            $display("FAIL overflow_count: cnt=%0d want %0d", fire_cnt, m_cnt[0]);
        end
        test_drain("ovf");
    endtask

    task automatic test_back_to_back();
        step(4'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (ev_mask !== exp_q[0].mask || ev_ts !== exp_q[0].ts) begin
            n_err++;
            $display("FAIL full_head: mask=%b ts=%0d want %b %0d", ev_mask, ev_ts, exp_q[0].mask, exp_q[0].ts);
        end
        step(4'b1000, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0 || exp_q.size() != 4) begin
            n_err++;
            $display("FAIL full_push_pop: ovf=%b drop=%0d, want 0 0", overflow, drop_cnt);
        end
        test_drain("b2b");
    endtask

    task automatic test_saturate();
        step(4'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(4'b0001, 1'b1, 1'b0, 1'b0);
        cnt_sel = 4'd0; #1;
        n_vec++;
        if (fire_cnt !== 8'd255 || drop_cnt !== 8'd255 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL saturate: cnt=%0d drop=%0d ovf=%b, want 255 255 1", fire_cnt, drop_cnt, overflow);
        end
        step(4'b1111, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if ({sticky, any_fire, first_valid, first_mask, first_ts, ev_valid, overflow, drop_cnt} !== '0) begin
            n_err++;
            $display("FAIL clear_state: sticky=%b fv=%b evv=%b ovf=%b drop=%0d, want all 0",
                     sticky, first_valid, ev_valid, overflow, drop_cnt);
        end
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 4'(s); #1;
            n_vec++;
            if (fire_cnt !== 8'd0) begin
                n_err++;
                $display("FAIL clear_cnt%0d: cnt=%0d want 0", s, fire_cnt);
            end
        end
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        cnt_sel = 4'd3; #1;
        n_vec++;
        if (sticky !== 4'd0 || ev_valid !== 1'b0 || first_valid !== 1'b0 || fire_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL disabled: sticky=%b evv=%b fv=%b cnt=%0d, want 0", sticky, ev_valid, first_valid, fire_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (ev_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midstream_queued: evv=%b want 1", ev_valid);
        end
        reset = 1'b0;
        #2;
        n_vec++;
        if (ev_valid !== 1'b0 || sticky !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset: evv=%b sticky=%b, want 0 0", ev_valid, sticky);
        end
        model_clear();
        @(posedge clock); #1;
        reset = 1'b1;
        mts = 16'd0;
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (first_valid !== 1'b1 || first_ts !== 16'd0 || first_mask !== 4'b0010) begin
            n_err++;
            $display("FAIL post_reset_first: fv=%b ts=%0d mask=%b, want 1 0 0010", first_valid, first_ts, first_mask);
        end
        test_drain("post_reset");
    endtask

    initial begin
        mts = 16'd0;
        test_reset();
        test_first_fail();
        test_overflow();
        test_back_to_back();
        test_saturate();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ivl_uvm_ovl_fire_monitor.md
Name: ivl_uvm_ovl_fire_monitor

Overview:
- Downstream consumer of the OVL checker fire outputs (ovl_window and siblings) in the ivl_uvm OVL test benches.
- Samples a vector of per-checker assertion-fire pulses every clock and keeps sticky status and saturating per-checker fire counts.
- Captures the first failure with a cycle timestamp.
- Queues every fire event into a small FIFO that the UVM monitor drains over a valid/ready handshake.

Parameters:
- NUM_CHK, 4: number of checker fire inputs (1..16).
- CNT_W, 8: width of each per-checker saturating fire counter.
- TS_W, 16: width of the free-running cycle timestamp.
- FIFO_DEPTH, 4: event FIFO entries (power of 2, >=2).

Ports:
- clock, input, 1: single clock, all state on posedge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: when 0, fire_in is ignored (no count, no sticky, no push); timestamp still runs.
- clear, input, 1: synchronous clear of monitor state (see Behaviour).
- fire_in, input, NUM_CHK: bit i = checker i fired this cycle.
- cnt_sel, input, 4: selects the counter shown on fire_cnt.
- fire_cnt, output, CNT_W: combinational count of checker cnt_sel; 0 if cnt_sel >= NUM_CHK.
- sticky, output, NUM_CHK: bit i set once checker i has fired.
- any_fire, output, 1: OR of sticky.
- first_valid, output, 1: a first-failure capture is held.
- first_mask, output, NUM_CHK: fire_in mask at the first failure.
- first_ts, output, TS_W: timestamp of the first failure.
- ev_valid, output, 1: FIFO head valid.
- ev_ready, input, 1: consumer accepts head when ev_valid && ev_ready.
- ev_mask, output, NUM_CHK: fire mask of the head event.
- ev_ts, output, TS_W: timestamp of the head event.
- overflow, output, 1: sticky; at least one event was dropped.
- drop_cnt, output, 8: dropped events, saturating at 255.

Behaviour:
Reset (reset=0, asynchronous):
- All outputs 0, counters 0, FIFO empty, timestamp 0.
- Reset asserted mid-operation discards FIFO contents immediately.

Timestamp:
- ts increments every clock after reset release and wraps from 2^TS_W-1 to 0.
- An event sampled at an edge records the pre-increment ts value.
- clear does not affect ts.

Sampling:
- An event exists at a posedge when enable=1, clear=0 and fire_in != 0.
- On an event, for each set bit i: sticky[i] <= 1; counter[i] increments and saturates at 2^CNT_W-1.
- All outputs update at the sampling edge, giving 1-cycle latency from fire_in to sticky, fire_cnt and ev_valid.
- A fire held high for N cycles produces N events and N counts.

First failure:
- On the first event while first_valid=0: first_valid <= 1, first_mask <= fire_in, first_ts <= ts.
- Later events do not update the capture until clear.

Event FIFO:
- Each event pushes {fire_in, ts}.
- Pop occurs when ev_valid && ev_ready.
- Show-ahead: ev_mask and ev_ts are the head entry, stable while ev_valid && !ev_ready.
- Full and push without pop: event dropped, overflow <= 1, drop_cnt increments (saturating). Counters and sticky still update.
- Full with push and pop in the same cycle: both occur, no drop, occupancy unchanged.
- Empty with push: ev_valid is 1 on the next cycle. There is no same-cycle bypass.
- Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.

Clear:
- Clears counters, sticky, first_*, FIFO, overflow and drop_cnt at the next edge.
- clear has priority: fire_in and ev_ready in a clear cycle are ignored.

Test Plan:
1. Reset release, then fire_in=0 for 10 cycles -> all outputs 0; ts at cycle 10 = 10.
2. fire_in=4'b0010 for 3 cycles starting at ts=5 -> sticky=0010, fire_cnt(sel=1)=3. first_mask=0010, first_ts=5. Three FIFO entries with ts 5,6,7.
3. ev_ready=0, then 6 consecutive events with fire_in=0001 (DEPTH=4) -> entries 1-4 kept, overflow=1, drop_cnt=2. Then ev_ready=1 -> 4 pops in order, then ev_valid=0.
4. FIFO full and ev_ready=1 with fire_in=1000 in the same cycle -> no drop, occupancy stays 4, new tail ts correct.
5. fire_in=0001 held 300 cycles with CNT_W=8 -> fire_cnt saturates at 255. Then clear=1 together with fire_in=1111 -> all cleared, no count from that cycle. enable=0 with fire_in=1111 -> no change.
6. Reset asserted mid-stream with 2 queued events -> ev_valid drops to 0 asynchronously. After release, ts restarts at 0 and a new event gets first_ts=0.
